// File: rtl/bram_tdp_param.sv
// Behavioural true-dual-port block RAM with byte write enables, selectable
// same-port read-during-write behaviour and an optional output pipeline stage.
module bram_tdp_param #(
    parameter int               DEPTH      = 1024,
    parameter int               WIDTH      = 16,
    parameter int               BYTE_W     = 8,
    parameter logic [1:0]       WRITE_MODE = 2'd0,
    parameter bit               OUT_REG    = 1'b0,
    parameter logic [WIDTH-1:0] RST_VAL    = {WIDTH{1'b0}},
    parameter int               AW         = $clog2(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    a_en,
    input  logic [WIDTH/BYTE_W-1:0] a_we,
    input  logic [AW-1:0]           a_addr,
    input  logic [WIDTH-1:0]        a_din,
    output logic [WIDTH-1:0]        a_dout,
    input  logic                    b_en,
    input  logic [WIDTH/BYTE_W-1:0] b_we,
    input  logic [AW-1:0]           b_addr,
    input  logic [WIDTH-1:0]        b_din,
    output logic [WIDTH-1:0]        b_dout
);
    localparam int         WE_W             = WIDTH / BYTE_W;
    localparam logic [1:0] MODE_WRITE_FIRST = 2'd1;
    localparam logic [1:0] MODE_NO_CHANGE   = 2'd2;

    logic [WIDTH-1:0] r_mem [DEPTH] = '{default: {WIDTH{1'b0}}};
    logic [WIDTH-1:0] r_a_data;
    logic [WIDTH-1:0] r_b_data;
    logic [WIDTH-1:0] w_a_old;
    logic [WIDTH-1:0] w_b_old;
    logic [WIDTH-1:0] w_a_merged;
    logic [WIDTH-1:0] w_b_merged;
    logic [WIDTH-1:0] w_a_wdata;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;
    logic             w_a_wr;
    logic             w_b_wr;

    function automatic logic [WIDTH-1:0] merge_lanes(
        input logic [WIDTH-1:0] old_word,
        input logic [WIDTH-1:0] new_word,
        input logic [WE_W-1:0]  we
    );
        logic [WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < WE_W; i++) begin
            if (we[i]) begin
                merged[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
            end else begin
                merged[i*BYTE_W +: BYTE_W] = old_word[i*BYTE_W +: BYTE_W];
            end
        end
        return merged;
    endfunction

    function automatic logic [WIDTH-1:0] next_data(
        input logic             en,
        input logic             wr,
        input logic [WIDTH-1:0] held,
        input logic [WIDTH-1:0] old_word,
        input logic [WIDTH-1:0] merged
    );
        logic [WIDTH-1:0] nd;
        nd = held;
        if (!en) begin
            nd = held;
        end else if (!wr) begin
            nd = old_word;
        end else begin
            case (WRITE_MODE)
                MODE_WRITE_FIRST: nd = merged;
                MODE_NO_CHANGE:   nd = held;
                default:          nd = old_word;
            endcase
        end
        return nd;
    endfunction

    // Pre-write words, lane merges and next data-register values for both ports
    always_comb begin
        w_a_old    = r_mem[a_addr];
        w_b_old    = r_mem[b_addr];
        w_a_wr     = a_en & (|a_we);
        w_b_wr     = b_en & (|b_we);
        w_a_merged = merge_lanes(w_a_old, a_din, a_we);
        w_b_merged = merge_lanes(w_b_old, b_din, b_we);
        // Same-address double write: A's lanes are layered over B's result
        if (w_a_wr && w_b_wr && (a_addr == b_addr)) begin
            w_a_wdata = merge_lanes(w_b_merged, a_din, a_we);
        end else begin
            w_a_wdata = w_a_merged;
        end
        w_a_next = next_data(a_en, w_a_wr, r_a_data, w_a_old, w_a_merged);
        w_b_next = next_data(b_en, w_b_wr, r_b_data, w_b_old, w_b_merged);
    end

    // Storage update; A is written last so it wins on a shared address
    always_ff @(posedge clock) begin
        if (w_b_wr) begin
            r_mem[b_addr] <= w_b_merged;
        end
        if (w_a_wr) begin
            r_mem[a_addr] <= w_a_wdata;
        end
    end

    // Port data registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_a_data <= RST_VAL;
            r_b_data <= RST_VAL;
        end else begin
            r_a_data <= w_a_next;
            r_b_data <= w_b_next;
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic [WIDTH-1:0] r_a_pipe;
            logic [WIDTH-1:0] r_b_pipe;

            // Output pipeline stage, loaded every cycle
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_a_pipe <= RST_VAL;
                    r_b_pipe <= RST_VAL;
                end else begin
                    r_a_pipe <= r_a_data;
                    r_b_pipe <= r_b_data;
                end
            end

            assign a_dout = r_a_pipe;
            assign b_dout = r_b_pipe;
        end else begin : g_no_out_reg
            assign a_dout = r_a_data;
            assign b_dout = r_b_data;
        end
    endgenerate

endmodule

// File: tb/tb_bram_tdp_param.sv
// Scoreboard bench for bram_tdp_param: four instances (three write modes and a
// pipelined one) share directed stimulus; a negedge monitor checks due entries.
module tb_bram_tdp_param;
    logic        clock = 1'b0;
    logic        reset;
    logic        a_en, b_en;
    logic [1:0]  a_we, b_we;
    logic [9:0]  a_addr, b_addr;
    logic [15:0] a_din, b_din;
    logic [15:0] rf_a, rf_b, wf_a, wf_b, nc_a, nc_b, p_a, p_b;

    always #5 clock = ~clock;

    bram_tdp_param #(.WRITE_MODE(2'd0)) u_rf (
        .clock(clock), .reset(reset),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(rf_a),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(rf_b));
    bram_tdp_param #(.WRITE_MODE(2'd1)) u_wf (
        .clock(clock), .reset(reset),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(wf_a),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(wf_b));
    bram_tdp_param #(.WRITE_MODE(2'd2)) u_nc (
        .clock(clock), .reset(reset),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(nc_a),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(nc_b));
    bram_tdp_param #(.WRITE_MODE(2'd0), .OUT_REG(1'b1), .RST_VAL(16'hDEAD)) u_pipe (
        .clock(clock), .reset(reset),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(p_a),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(p_b));

    typedef struct {
        int          due;
        int          id;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;

    function automatic string name_of(input int id);
        case (id)
            0:       return "rf_a_dout";
            1:       return "wf_a_dout";
            2:       return "nc_a_dout";
            3:       return "pipe_a_dout";
            4:       return "rf_b_dout";
            5:       return "wf_b_dout";
            default: return "nc_b_dout";
        endcase
    endfunction

    function automatic logic [15:0] actual_of(input int id);
        case (id)
            0:       return rf_a;
            1:       return wf_a;
            2:       return nc_a;
            3:       return p_a;
            4:       return rf_b;
            5:       return wf_b;
            default: return nc_b;
        endcase
    endfunction

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    // Monitor: compare every scoreboard entry due at this cycle
    always @(negedge clock) begin
        logic [15:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == edge_cnt) begin
                act = actual_of(sb[i].id);
                n_cmp++;
                if (act !== sb[i].exp) begin
                    n_bad++;
                    $display("FAIL %s @edge %0d: got %h expected %h",
                             name_of(sb[i].id), edge_cnt, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic push(input int id, input int due, input logic [15:0] exp);
        exp_t e;
        e.id  = id;
        e.due = due;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // One clock of stimulus; e_p is the pipelined instance's data-register value
    task automatic step(
        input logic rst,
        input logic ae, input logic [1:0] awe, input logic [9:0] aaddr, input logic [15:0] adin,
        input logic be, input logic [1:0] bwe, input logic [9:0] baddr, input logic [15:0] bdin,
        input logic [15:0] e_rf, input logic [15:0] e_wf, input logic [15:0] e_nc,
        input logic [15:0] e_p, input logic [15:0] e_b, input bit chk_b
    );
        int due;
        reset = rst;
        a_en = ae; a_we = awe; a_addr = aaddr; a_din = adin;
        b_en = be; b_we = bwe; b_addr = baddr; b_din = bdin;
        due = edge_cnt + 1;
        if (rst) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].id == 3 && sb[i].due >= due) sb.delete(i);
            end
            push(3, due, 16'hDEAD);
        end
        push(0, due, e_rf);
        push(1, due, e_wf);
        push(2, due, e_nc);
        push(3, due + 1, e_p);
        if (chk_b) begin
            push(4, due, e_b);
            push(5, due, e_b);
            push(6, due, e_b);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_en = 1'b0; a_we = 2'b00; a_addr = 10'd0; a_din = 16'h0000;
        b_en = 1'b0; b_we = 2'b00; b_addr = 10'd0; b_din = 16'h0000;

        repeat (2) step(1'b1, 1'b0, 2'b00, 10'd0, 16'h0000, 1'b0, 2'b00, 10'd0, 16'h0000,
                        16'h0000, 16'h0000, 16'h0000, 16'hDEAD, 16'h0000, 1'b1);

        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 2'b11, 10'(i), 16'h0010 + 16'(i), 1'b0, 2'b00, 10'd0, 16'h0000,
                 16'h0000, 16'h0010 + 16'(i), 16'h0000, 16'h0000, 16'h0000, 1'b1);
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b0, 2'b00, 10'd0, 16'h0000, 1'b1, 2'b00, 10'(i), 16'h0000,
                 16'h0000, 16'h0017, 16'h0000, 16'h0000, 16'h0010 + 16'(i), 1'b1);

        // Read-during-write modes on address 5
        step(1'b0, 1'b0, 2'b00, 10'd0, 16'h0000, 1'b1, 2'b11, 10'd5, 16'h1234,
             16'h0000, 16'h0017, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 2'b11, 10'd5, 16'hABCD, 1'b0, 2'b00, 10'd0, 16'h0000,
             16'h1234, 16'hABCD, 16'h0000, 16'h1234, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 2'b00, 10'd5, 16'h0000, 1'b1, 2'b00, 10'd5, 16'h0000,
             16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD, 1'b1);

        // Byte enables on address 3
        step(1'b0, 1'b0, 2'b00, 10'd0, 16'h0000, 1'b1, 2'b11, 10'd3, 16'h1111,
             16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 2'b01, 10'd3, 16'hFFEE, 1'b0, 2'b00, 10'd0, 16'h0000,
             16'h1111, 16'h11EE, 16'hABCD, 16'h1111, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 2'b00, 10'd3, 16'h0000, 1'b1, 2'b00, 10'd3, 16'h0000,
             16'h11EE, 16'h11EE, 16'h11EE, 16'h11EE, 16'h11EE, 1'b1);

        // Cross-port collisions on address 9
        step(1'b0, 1'b1, 2'b11, 10'd9, 16'hAAAA, 1'b1, 2'b11, 10'd9, 16'h5555,
             16'h0000, 16'hAAAA, 16'h11EE, 16'h0000, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 2'b00, 10'd9, 16'h0000, 1'b1, 2'b00, 10'd9, 16'h0000,
             16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 1'b1);
        step(1'b0, 1'b0, 2'b00, 10'd0, 16'h0000, 1'b1, 2'b11, 10'd9, 16'h5555,
             16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 2'b11, 10'd9, 16'h7777, 1'b1, 2'b00, 10'd9, 16'h0000,
             16'h5555, 16'h7777, 16'hAAAA, 16'h5555, 16'h5555, 1'b1);
        step(1'b0, 1'b1, 2'b00, 10'd9, 16'h0000, 1'b0, 2'b00, 10'd0, 16'h0000,
             16'h7777, 16'h7777, 16'h7777, 16'h7777, 16'h5555, 1'b1);

        // Lane-level collision on address 4: A owns the upper lane, B both
        step(1'b0, 1'b1, 2'b10, 10'd4, 16'h1234, 1'b1, 2'b11, 10'd4, 16'h9956,
             16'h0014, 16'h1214, 16'h7777, 16'h0014, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 2'b00, 10'd4, 16'h0000, 1'b1, 2'b00, 10'd4, 16'h0000,
             16'h1256, 16'h1256, 16'h1256, 16'h1256, 16'h1256, 1'b1);

        // Enable gating: write enables with a_en low do nothing
        step(1'b0, 1'b0, 2'b11, 10'd4, 16'hFFFF, 1'b0, 2'b00, 10'd0, 16'h0000,
             16'h1256, 16'h1256, 16'h1256, 16'h1256, 16'h1256, 1'b1);
        step(1'b0, 1'b1, 2'b00, 10'd4, 16'h0000, 1'b0, 2'b00, 10'd0, 16'h0000,
             16'h1256, 16'h1256, 16'h1256, 16'h1256, 16'h1256, 1'b1);

        // Pipeline with reset while reads are in flight; B writes during reset
        step(1'b0, 1'b1, 2'b00, 10'd2, 16'h0000, 1'b0, 2'b00, 10'd0, 16'h0000,
             16'h0012, 16'h0012, 16'h0012, 16'h0012, 16'h1256, 1'b1);
        step(1'b0, 1'b1, 2'b00, 10'd6, 16'h0000, 1'b0, 2'b00, 10'd0, 16'h0000,
             16'h0016, 16'h0016, 16'h0016, 16'h0016, 16'h1256, 1'b1);
        step(1'b1, 1'b1, 2'b00, 10'd7, 16'h0000, 1'b1, 2'b11, 10'd10, 16'hBEEF,
             16'h0000, 16'h0000, 16'h0000, 16'hDEAD, 16'h0000, 1'b1);
        step(1'b0, 1'b1, 2'b00, 10'd2, 16'h0000, 1'b1, 2'b00, 10'd10, 16'h0000,
             16'h0012, 16'h0012, 16'h0012, 16'h0012, 16'hBEEF, 1'b1);
        step(1'b0, 1'b1, 2'b00, 10'd6, 16'h0000, 1'b0, 2'b00, 10'd0, 16'h0000,
             16'h0016, 16'h0016, 16'h0016, 16'h0016, 16'hBEEF, 1'b1);
        repeat (2) step(1'b0, 1'b0, 2'b00, 10'd0, 16'h0000, 1'b0, 2'b00, 10'd0, 16'h0000,
                        16'h0016, 16'h0016, 16'h0016, 16'h0016, 16'hBEEF, 1'b1);

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clock);
        @(negedge clock);
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries still pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bram_tdp_param.md
Name: bram_tdp_param

Overview:
- Parametrised behavioural true-dual-port block RAM model; next generation of the single-port 1024x16 behavioural BRAM18 model.
- Adds the following over the single-port model:
  - two independent read/write ports;
  - per-byte write enables;
  - selectable read-during-write mode;
  - optional output pipeline register.
- Used as the golden reference against mapped BRAM18/BRAM36 implementations in side-by-side comparison benches.

Parameters:
- DEPTH, 1024, number of words (power of two, 16..32768).
- WIDTH, 16, data bits per word (multiple of BYTE_W).
- BYTE_W, 8, bits per write-enable lane; WE_W = WIDTH/BYTE_W.
- WRITE_MODE, 0, same-port read-during-write: 0=READ_FIRST, 1=WRITE_FIRST, 2=NO_CHANGE.
- OUT_REG, 0, 1 adds an output pipeline stage (read latency 2 instead of 1).
- RST_VAL, 0, value loaded into output registers on reset.
- AW, $clog2(DEPTH), address width (derived, do not override).

Ports:
- clock  in  1  single clock for both ports.
- reset  in  1  synchronous, active-high; clears output/pipeline registers only.
- a_en  in  1  port A enable; no read or write when low.
- a_we  in  WE_W  port A byte write enables (bit i writes bits [i*BYTE_W +: BYTE_W]).
- a_addr  in  AW  port A address.
- a_din  in  WIDTH  port A write data.
- a_dout  out  WIDTH  port A read data.
- b_en, b_we, b_addr, b_din, b_dout: same as port A, for port B.

Behaviour:
- Storage is DEPTH x WIDTH. Initial content is all zero. Memory is never cleared by reset.
- Access at a rising clock edge with x_en=1:
  - lanes with x_we[i]=1 are written from x_din;
  - a read of x_addr is captured into the port's data register.
- x_en=0: the port's data register holds its previous value; no write.
- Same-port read-during-write (x_en=1 and any x_we bit set):
  - READ_FIRST: data register gets the pre-write word.
  - WRITE_FIRST: data register gets the post-write word (written lanes new, unwritten lanes old).
  - NO_CHANGE: data register holds its previous value.
  - x_we=0 is a plain read in every mode.
- Latency:
  - OUT_REG=0: x_dout = data register; the word appears one cycle after the address.
  - OUT_REG=1: a second register loads from the data register every cycle (unconditionally); x_dout is valid two cycles after the address.
- Cross-port collision, both ports enabled with a_addr==b_addr in the same cycle:
  - Both write: for each lane written by both, port A's data wins; lanes written by only one port take that port's data.
  - One port writes, other reads: the reading port gets the pre-write word, regardless of WRITE_MODE.
  - The writing port follows its own WRITE_MODE.
- Reset (reset=1 at an edge):
  - all data and pipeline registers of both ports load RST_VAL;
  - writes presented in the same cycle are still performed;
  - reset has priority over en for the output registers.
- Reset mid-operation: in-flight reads are discarded and outputs show RST_VAL. The first valid read after reset appears at the normal latency.
- Address range: addresses are AW bits wide, so with power-of-two DEPTH there is no out-of-range address and no wrap handling.
- Writes are visible to any port's read issued on the following cycle.

Test Plan:
- Single-port sweep (DEPTH=1024, WIDTH=16, OUT_REG=0):
  - stimulus: write data=addr+0x10 to addr 0..7 on A, then read 0..7 on B;
  - required: b_dout = 0x0010..0x0017, each one cycle after its address.
- Mode check: memory[5]=0x1234, then A writes 0xABCD to addr 5 with a_we=2'b11:
  - READ_FIRST: a_dout=0x1234.
  - WRITE_FIRST: a_dout=0xABCD.
  - NO_CHANGE: a_dout holds its prior value.
  - In all modes, a subsequent read of addr 5 returns 0xABCD.
- Byte enables: memory[3]=0x1111, A writes 0xFFEE with a_we=2'b01 -> a later read of addr 3 returns 0x11EE.
- Collision, same cycle at addr 9:
  - A writes 0xAAAA, B writes 0x5555 -> a later read returns 0xAAAA.
  - A writes 0x7777 while B reads, with old content 0x5555 -> b_dout=0x5555.
- Pipeline and reset (OUT_REG=1, RST_VAL=0xDEAD):
  - read addr 2 -> data appears two cycles later;
  - assert reset while two reads are in flight -> a_dout=0xDEAD the cycle after reset; memory content unchanged on re-read.
- Enable gating: a_en=0 with a_we=1 -> memory unchanged and a_dout holds its last value.
